// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU load/store path (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, WAIT_CYCLES latency, byte strobes, error on bad address.
// Optional access counters are compiled in when DMEM_ACCESS_CNT_EN is defined.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [15:0]       err_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             acc_wr;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_wstrb;
    logic [31:0]      word_off;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_err;
    logic             enter_resp;
    logic             mem_we;

    // With zero wait the access resolves straight from the bus in IDLE; otherwise from the captured request.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_wr    = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_wstrb = bus.req_wstrb;
        end else begin
            acc_wr    = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
        end
        word_off = (acc_addr - BASE_ADDR) >> 2;
        acc_idx  = word_off[IDX_W-1:0];
        acc_err  = (acc_addr[1:0] != 2'b00) || (word_off >= 32'(DEPTH_WORDS));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        enter_resp  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    if (WAIT_CYCLES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) enter_resp = 1'b1;
                else               cnt_d      = cnt_q - 4'd1;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            state_d     = S_RESP;
            cnt_d       = '0;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_wr) ? 32'h0 : mem[acc_idx];
        end

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    // Gating with reset keeps a zero-wait store from committing while reset is held.
    assign mem_we = enter_resp && acc_wr && !acc_err && reset;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DMEM_ACCESS_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic        rsp_hs;

    always_comb begin
        rsp_hs      = (state_q == S_RESP) && bus.rsp_ready;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        if (rsp_hs) begin
            if (rsp_err_q)  err_count_d = sat_inc(err_count_q);
            else if (wr_q)  wr_count_d  = sat_inc(wr_count_q);
            else            rd_count_d  = sat_inc(rd_count_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, hand-written multi-cycle sequences and a randomized run against a word-array model.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    logic [15:0] rd_cnt0, wr_cnt0, err_cnt0;
    logic [15:0] rd_cnt1, wr_cnt1, err_cnt1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0)
`ifdef DMEM_ACCESS_CNT_EN
        , .rd_count(rd_cnt0), .wr_count(wr_cnt0), .err_count(err_cnt0)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .reset(rst_n), .bus(bus1)
`ifdef DMEM_ACCESS_CNT_EN
        , .rd_count(rd_cnt1), .wr_count(wr_cnt1), .err_count(err_cnt1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [DEPTH];
    bit          written [DEPTH];
    int          t_rd = 0, t_wr = 0, t_err = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    // Reference: byte-addressed words relative to base 0, plain arithmetic.
    function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] strb, output logic [31:0] rd, output bit er);
        longint unsigned idx = longint'(addr) / 4;
        rd = 32'h0;
        er = (addr % 4 != 0) || (idx >= DEPTH);
        if (er) t_err++;
        else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
            written[idx] = 1'b1;
            t_wr++;
        end else begin
            rd = mdl[idx];
            t_rd++;
        end
    endfunction

    task automatic start_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        int g = 0;
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_write = wr;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        bus0.req_wstrb = strb;
        while (!bus0.req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!bus0.req_ready) timeout("req_accept");
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
    endtask

    // Latency = edges from the accept edge to the first edge that sees rsp_valid high.
    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
        lat = 1;
        rd  = 'x;
        er  = 'x;
        forever begin
            @(negedge clk);
            if (bus0.rsp_valid) begin
                rd = bus0.rsp_rdata;
                er = bus0.rsp_err;
                break;
            end
            if (lat > 40) begin
                timeout("rsp_valid");
                break;
            end
            lat++;
        end
    endtask

    task automatic finish_rsp(input int delay);
        repeat (delay) @(negedge clk);
        bus0.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.rsp_ready = 1'b0;
    endtask

    task automatic txn(input string nm, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int delay, output logic [31:0] rd, output logic er);
        int          lat;
        logic [31:0] m_rd;
        bit          m_er;
        start_req(wr, addr, wdata, strb);
        wait_rsp(lat, rd, er);
        finish_rsp(delay);
        model(wr, addr, wdata, strb, m_rd, m_er);
        chk({nm, "_rdata"}, rd, m_rd);
        chk({nm, "_err"}, 32'(er), 32'(m_er));
        chk({nm, "_latency"}, 32'(lat), 32'(WAITC + 1));
    endtask

    initial begin
        logic [31:0] rd, hold_rd;
        logic        er, hold_er;
        int          lat;

        bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
        bus0.req_wstrb = 0; bus0.rsp_ready = 0;
        bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
        bus1.req_wstrb = 0; bus1.rsp_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i] = 32'h0;
            written[i] = 1'b0;
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus0.rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(bus0.rsp_err), 32'd0);
        rst_n = 1'b1;

        tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{1'b1, 32'h0,        32'hCAFEBABE, 4'hF, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 32'h22,       32'h0,        4'h0, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 32'h400,      32'h0,        4'h0, 32'h0,        1'b1};
        tbl[8]  = '{1'b1, 32'h400,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 32'h0,        32'h0,        4'hF, 32'hCAFEBABE, 1'b0};
        tbl[10] = '{1'b1, 32'h10,       32'h55667788, 4'h0, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h10,       32'h0,        4'hA, 32'hDEADBEEF, 1'b0};
        tbl[12] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};

        foreach (tbl[i]) begin
            logic [31:0] m_rd;
            bit          m_er;
            start_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb);
            wait_rsp(lat, rd, er);
            finish_rsp(i % 3);
            model(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, m_rd, m_er);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
            if (i == 0) chk("vec0_latency", 32'(lat), 32'd3);
        end

        // Back-pressure: response held for 5 cycles, competing request must be ignored.
        start_req(1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(lat, hold_rd, hold_er);
        chk("bp_first_rdata", hold_rd, 32'h11BB33DD);
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h20;
        bus0.req_wdata = 32'h0; bus0.req_wstrb = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_rsp_valid", c), 32'(bus0.rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rdata", c), bus0.rsp_rdata, hold_rd);
            chk($sformatf("bp%0d_err", c), 32'(bus0.rsp_err), 32'(hold_er));
            chk($sformatf("bp%0d_req_ready", c), 32'(bus0.req_ready), 32'd0);
        end
        bus0.req_valid = 1'b0;
        bus0.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_done_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("bp_done_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("bp_done_rdata", bus0.rsp_rdata, 32'h0);
        t_rd++;
        txn("bp_after", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);

        // Reset during WAIT discards the store.
        txn("pre30", 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0, rd, er);
        start_req(1'b1, 32'h30, 32'h12345678, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstwait_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("rstwait_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("rstwait_rdata", bus0.rsp_rdata, 32'h0);
        chk("rstwait_err", 32'(bus0.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t_rd = 0; t_wr = 0; t_err = 0;
        txn("post30", 1'b0, 32'h30, 32'h0, 4'h0, 1, rd, er);

        // Reset during RESP drops the response but keeps the committed store.
        start_req(1'b1, 32'h34, 32'h0BADF00D, 4'hF);
        wait_rsp(lat, rd, er);
        rst_n = 1'b0;
        #1 chk("rstresp_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        mdl[13] = 32'h0BADF00D;
        written[13] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t_rd = 0; t_wr = 0; t_err = 0;
        txn("post34", 1'b0, 32'h34, 32'h0, 4'h0, 0, rd, er);

        // Zero-wait instance: response visible one edge after accept.
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 32'h8;
        bus1.req_wdata = 32'h01020304; bus1.req_wstrb = 4'hF;
        @(posedge clk);
        #1 bus1.req_valid = 1'b0;
        @(negedge clk);
        chk("w0_store_valid", 32'(bus1.rsp_valid), 32'd1);
        chk("w0_store_err", 32'(bus1.rsp_err), 32'd0);
        bus1.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus1.rsp_ready = 1'b0;
        @(negedge clk);
        chk("w0_idle_req_ready", 32'(bus1.req_ready), 32'd1);
        bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 32'h8;
        @(posedge clk);
        #1 bus1.req_valid = 1'b0;
        @(negedge clk);
        chk("w0_load_valid", 32'(bus1.rsp_valid), 32'd1);
        chk("w0_load_rdata", bus1.rsp_rdata, 32'h01020304);
        bus1.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus1.rsp_ready = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 150; k++) begin
            int          kind = $urandom_range(0, 9);
            bit          wr = 1'($urandom);
            logic [31:0] addr;
            if (kind == 0)      addr = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
            else if (kind == 1) addr = 32'h400 + {$urandom_range(0, 1000), 2'b00};
            else                addr = {24'h0, 4'($urandom_range(0, 15)), 2'b00};
            if (kind > 1 && !written[addr / 4]) wr = 1'b1;
            txn($sformatf("rnd%0d", k), wr, addr, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
        end

`ifdef DMEM_ACCESS_CNT_EN
        @(negedge clk);
        chk("cnt_rd", 32'(rd_cnt0), 32'(t_rd));
        chk("cnt_wr", 32'(wr_cnt0), 32'(t_wr));
        chk("cnt_err", 32'(err_cnt0), 32'(t_err));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end
endmodule
